// File: rtl/cpu_pkg.sv
// Shared CPU package: multiplier FSM state encoding and iteration constants.
package cpu_pkg;

    // Multiplier control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } multState_t;

    // Number of radix-2 Booth iterations for a 32-bit multiplier
    localparam int MULT_ITER  = 32;

    // Iteration counter width; wide enough that the counter never wraps
    localparam int MULT_CNT_W = 6;

    // Counter value on which the final Booth step is taken
    localparam logic [MULT_CNT_W-1:0] MULT_LAST_ITER = MULT_CNT_W'(MULT_ITER - 1);

endpackage : cpu_pkg

// File: rtl/booth_step.sv
// Single radix-2 Booth step on the 65-bit accumulator {upper, multiplier, q-1}.
// The upper half is handled as a 33-bit value so that subtracting a
// multiplicand of -2^31 cannot overflow before the arithmetic shift.
module booth_step
    import cpu_pkg::*;
(
    input  logic [64:0] accum,
    input  logic [31:0] mcand,
    output logic [64:0] nextAccum
);

    logic [32:0] upperExt_s;
    logic [32:0] mcandExt_s;
    logic [32:0] sum_s;

    assign upperExt_s = {accum[64], accum[64:33]};
    assign mcandExt_s = {mcand[31], mcand};

    // Add/subtract the multiplicand according to the {q0, q-1} Booth pair
    always_comb begin
        sum_s = upperExt_s;
        case (accum[1:0])
            2'b10:   sum_s = upperExt_s - mcandExt_s;
            2'b01:   sum_s = upperExt_s + mcandExt_s;
            default: sum_s = upperExt_s;
        endcase
    end

    // Arithmetic right shift of {sum, multiplier, q-1} by one; the dropped
    // sign-copy bit is redundant because the 33-bit sum keeps the sign.
    assign nextAccum = {sum_s, accum[32:1]};

endmodule : booth_step

// File: rtl/booth_mult.sv
// Sequential 32x32 signed multiplier, radix-2 Booth, one step per clock.
// Optional build macro: BOOTH_MULT_ZERO_SKIP_EN -- when defined, a zero
// operand bypasses the iteration phase and completes one cycle after start.
module booth_mult
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    multState_t            state_r;
    logic [MULT_CNT_W-1:0] iterCnt_r;
    logic [64:0]           accum_r;
    logic [31:0]           mcand_r;
    logic                  busy_r;
    logic                  done_r;
    logic [31:0]           hi_r;
    logic [31:0]           lo_r;
    logic [64:0]           nextAccum_s;
    logic                  zeroOperand_s;

    booth_step uStep (
        .accum     (accum_r),
        .mcand     (mcand_r),
        .nextAccum (nextAccum_s)
    );

`ifdef BOOTH_MULT_ZERO_SKIP_EN
    // A zero operand makes the product zero without iterating
    always_comb begin
        zeroOperand_s = 1'b0;
        if ((a == 32'd0) || (b == 32'd0)) begin
            zeroOperand_s = 1'b1;
        end else begin
            zeroOperand_s = 1'b0;
        end
    end
`else
    // Every operand pair takes the full iteration latency
    always_comb begin
        zeroOperand_s = 1'b0;
    end
`endif

    // Control FSM, iteration counter, datapath registers and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            iterCnt_r <= {MULT_CNT_W{1'b0}};
            accum_r   <= 65'd0;
            mcand_r   <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mcand_r   <= a;
                        accum_r   <= {32'd0, b, 1'b0};
                        iterCnt_r <= {MULT_CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        if (zeroOperand_s) begin
                            hi_r    <= 32'd0;
                            lo_r    <= 32'd0;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            state_r <= CALC;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    accum_r <= nextAccum_s;
                    busy_r  <= 1'b1;
                    if (iterCnt_r == MULT_LAST_ITER) begin
                        // Final step: publish the product from this step's result
                        hi_r    <= nextAccum_s[64:33];
                        lo_r    <= nextAccum_s[32:1];
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        iterCnt_r <= iterCnt_r + {{(MULT_CNT_W-1){1'b0}}, 1'b1};
                        done_r    <= 1'b0;
                        state_r   <= CALC;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule : booth_mult

// File: tb/tb_booth_mult.sv
// Directed self-checking bench for booth_mult.
module tb_booth_mult;

    logic        clock;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    booth_mult dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .start (start),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; returns 1 time unit after the start-sampling edge
    task automatic startOp(input logic [31:0] av, input logic [31:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; n = edges after the start edge when done is seen
    task automatic waitDone(input int startCnt, input int expLat,
                            input logic [31:0] expHi, input logic [31:0] expLo,
                            input string tag);
        int   n;
        logic held;
        logic busyOk;
        logic [31:0] h0;
        logic [31:0] l0;
        n      = startCnt;
        held   = 1'b1;
        busyOk = (busy === 1'b1);
        h0     = hi;
        l0     = lo;
        while ((done !== 1'b1) && (n < 100)) begin
            @(posedge clock);
            #1;
            n++;
            if (busy !== 1'b1) busyOk = 1'b0;
            if ((done !== 1'b1) && ((hi !== h0) || (lo !== l0))) held = 1'b0;
        end
        check({tag, ".latency"}, 64'(n), 64'(expLat));
        check({tag, ".holdDuringCalc"}, 64'(held), 64'd1);
        check({tag, ".busyDuringOp"}, 64'(busyOk), 64'd1);
        check({tag, ".doneBusy"}, 64'({done, busy}), 64'd3);
        check({tag, ".product"}, {hi, lo}, {expHi, expLo});
        @(posedge clock);
        #1;
        check({tag, ".doneFall"}, 64'({done, busy}), 64'd0);
        check({tag, ".productHold"}, {hi, lo}, {expHi, expLo});
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        a     = 32'd0;
        b     = 32'd0;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset.outputs", {30'd0, busy, done, hi}, 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        reset = 1'b0;

        // Start on the very first edge after reset release: 7 * -3 = -21
        startOp(32'd7, 32'hFFFFFFFD);
        waitDone(0, 32, 32'hFFFFFFFF, 32'hFFFFFFEB, "mul7xm3");

        // Most negative operand squared
        startOp(32'h80000000, 32'h80000000);
        waitDone(0, 32, 32'h40000000, 32'h00000000, "minSq");

        // Most positive operand squared, then -1 * -1
        startOp(32'h7FFFFFFF, 32'h7FFFFFFF);
        waitDone(0, 32, 32'h3FFFFFFF, 32'h00000001, "maxSq");
        startOp(32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone(0, 32, 32'h00000000, 32'h00000001, "m1Sq");

        // Start during CALC is ignored and operand changes have no effect
        startOp(32'd5, 32'd6);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        a     = 32'd9;
        b     = 32'd9;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a     = 32'd1234;
        b     = 32'd77;
        waitDone(10, 32, 32'd0, 32'd30, "ignoreStart");
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) pulses++;
        end
        check("ignoreStart.noSecondDone", 64'(pulses), 64'd0);

        // Reset in the middle of CALC discards the operation
        startOp(32'd5, 32'd6);
        repeat (14) begin
            @(posedge clock);
            #1;
        end
        #3;
        reset = 1'b1;
        #1;
        check("midReset.immediate", {30'd0, busy, done, hi}, 64'd0);
        check("midReset.lo", 64'(lo), 64'd0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if ((done === 1'b1) || (busy === 1'b1)) pulses++;
        end
        check("midReset.quiet", 64'(pulses), 64'd0);
        startOp(32'd3, 32'd4);
        waitDone(0, 32, 32'd0, 32'd12, "afterReset");

        // Zero operand: early completion only when the skip feature is built in
`ifdef BOOTH_MULT_ZERO_SKIP_EN
        startOp(32'd0, 32'h00001234);
        waitDone(0, 0, 32'd0, 32'd0, "zeroSkip");
`else
        startOp(32'd0, 32'h00001234);
        waitDone(0, 32, 32'd0, 32'd0, "zeroFull");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_booth_mult

// File: doc/booth_mult.md
BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 Port list (name  direction  width  meaning):
- clock  in  1  rising-edge clock
- reset  in  1  async active-high reset
- a  in  32  multiplicand, two's complement
- b  in  32  multiplier, two's complement
- start  in  1  request pulse from the datapath control
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle completion pulse
- hi  out  32  product bits 63:32
- lo  out  32  product bits 31:0
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The block SHALL compute the full 64-bit signed product a*b using radix-2 Booth recoding, one iteration per clock.
REQ-005 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-006 IDLE: when start=1 at a clock edge, the block SHALL latch a and b, clear the iteration counter, and go to CALC; otherwise it SHALL stay in IDLE.
REQ-007 CALC: each edge SHALL perform one Booth step on a 65-bit accumulator {upper 32, multiplier 32, q-1}.
- q0,q-1 = 10: upper minus multiplicand.
- q0,q-1 = 01: upper plus multiplicand.
- Then arithmetic right shift by 1.
- The upper half SHALL use 33-bit arithmetic so that a = -2^31 does not overflow.
REQ-008 After exactly 32 steps the block SHALL load hi/lo from the accumulator in the same edge, enter DONE, and assert done.
- done is therefore high in the cycle following the 32nd edge after the start-sampling edge.
REQ-009 DONE SHALL last exactly one cycle, then the block SHALL return to IDLE and deassert done.
REQ-010 busy SHALL be 1 in CALC and DONE, and 0 in IDLE.
REQ-011 start asserted in CALC or DONE SHALL be ignored; no queuing.
REQ-012 Changes on a or b after the start edge SHALL NOT affect the result.
REQ-013 hi and lo SHALL hold the last result until the next completion; they SHALL NOT change during CALC.
REQ-014 The 6-bit iteration counter SHALL NOT wrap: its terminal value 31 triggers the DONE transition.

Reset
REQ-015 On reset (including mid-CALC), the block SHALL set state=IDLE, counter=0, accumulator=0, hi=0, lo=0, done=0 and busy=0 immediately.
REQ-016 Any operation in progress at reset SHALL be discarded with no done pulse.
REQ-017 start sampled on the first edge after reset deasserts SHALL be accepted.

Configuration
REQ-018 Macro BOOTH_MULT_ZERO_SKIP_EN, when defined:
- If latched a==0 or b==0 at the start edge, the block SHALL skip CALC and enter DONE directly, with hi=lo=0.
- done is then high in the cycle after the start edge.
REQ-019 Without BOOTH_MULT_ZERO_SKIP_EN, all operands SHALL take the full 32-step latency.

Structure
REQ-020 The shared package cpu_pkg SHALL hold:
- the mult state enum (IDLE/CALC/DONE);
- the constant MULT_ITER = 32;
- the constant MULT_CNT_W = 6.
REQ-021 One combinational sub-module booth_step SHALL implement a single add/sub-and-shift on the 65-bit accumulator; booth_mult SHALL contain the FSM, counter and registers.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- a=7, b=-3 (0xFFFFFFFD), start pulse -> 32 edges later done=1 for 1 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high from start edge until done falls.
- a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001; then a=b=0xFFFFFFFF -> hi=0, lo=1.
- Start 5*6; at CALC step 10, pulse start with a=9, b=9 and change a/b -> single done, hi=0, lo=30.
- Start 5*6; assert reset at step 15 -> hi=lo=0, done never pulses, busy=0. Then after release start 3*4 -> lo=12 at the standard latency.
- With BOOTH_MULT_ZERO_SKIP_EN: a=0, b=0x1234 -> done one cycle after the start edge, hi=lo=0. Without the macro: same stimulus -> done after 32 edges, hi=lo=0.
